// File: rtl/irq_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : irq_conditioner
// Description : Per-source IRQ conditioning ahead of the PLIC: polarity fix,
//               synchroniser, debounce filter, enable mask, edge-to-pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_conditioner #(
    parameter int                  NUM_IRQS      = 32,
    parameter int                  SYNC_STAGES   = 2,
    parameter int                  FILTER_CYCLES = 4,
    parameter logic [NUM_IRQS-1:0] EDGE_MASK     = '0,
    parameter logic [NUM_IRQS-1:0] ACTIVE_LOW    = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_IRQS-1:0] irq_i,
    input  logic [NUM_IRQS-1:0] enable_i,
    output logic [NUM_IRQS-1:0] interrupts_o,
    output logic [NUM_IRQS-1:0] edge_trigger_o
);

    // Source 0 is reserved by the PLIC and never asserted.
    localparam logic [NUM_IRQS-1:0] c_src_mask = {{(NUM_IRQS-1){1'b1}}, 1'b0};

    logic [NUM_IRQS-1:0] w_pol;
    logic [NUM_IRQS-1:0] w_s;
    logic [NUM_IRQS-1:0] w_filt;
    logic [NUM_IRQS-1:0] r_filt_d;
    logic [NUM_IRQS-1:0] w_rise;

    assign w_pol = irq_i ^ ACTIVE_LOW;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [NUM_IRQS-1:0] r_sync [SYNC_STAGES];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int j = 0; j < SYNC_STAGES; j++) begin
                        r_sync[j] <= '0;
                    end
                end else begin
                    r_sync[0] <= w_pol;
                    for (int j = 1; j < SYNC_STAGES; j++) begin
                        r_sync[j] <= r_sync[j-1];
                    end
                end
            end

            assign w_s = r_sync[SYNC_STAGES-1];
        end else begin : g_nosync
            assign w_s = w_pol;
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_IRQS; i++) begin : g_src
            logic r_filt;

            if (FILTER_CYCLES > 0) begin : g_filter
                localparam int c_cnt_w = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
                localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILTER_CYCLES - 1);

                logic [c_cnt_w-1:0] r_cnt;

                // A new value is accepted only after FILTER_CYCLES consecutive
                // disagreeing samples; any agreeing sample restarts the count.
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        r_filt <= 1'b0;
                        r_cnt  <= '0;
                    end else if (w_s[i] == r_filt) begin
                        r_cnt  <= '0;
                    end else if (r_cnt == c_cnt_max) begin
                        r_filt <= w_s[i];
                        r_cnt  <= '0;
                    end else begin
                        r_cnt  <= r_cnt + c_cnt_w'(1);
                    end
                end
            end else begin : g_bypass
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        r_filt <= 1'b0;
                    end else begin
                        r_filt <= w_s[i];
                    end
                end
            end

            assign w_filt[i] = r_filt;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_filt_d <= '0;
        end else begin
            r_filt_d <= w_filt;
        end
    end

    assign w_rise = w_filt & ~r_filt_d;

    // Enable gates only the output, so an edge accepted while disabled is lost.
    assign interrupts_o   = ((EDGE_MASK & w_rise) | (~EDGE_MASK & w_filt))
                            & enable_i & c_src_mask;
    assign edge_trigger_o = EDGE_MASK & c_src_mask;

endmodule
`default_nettype wire

// File: doc/irq_conditioner.md
Name: irq_conditioner

Overview:
- Conditions raw device interrupt lines before they reach the PLIC `interrupts_i` / `edge_trigger_i` inputs.
- Sits directly upstream of the PLIC, replacing the ad-hoc IRQ routing block in the top level.
- Per source, in order: polarity correction, multi-flop synchronisation (for io_clk-domain devices), glitch filtering by debounce counter, enable masking.
- Edge-type sources are then converted to single-cycle pulses; level-type sources pass through as levels.

Parameters:
- NumIrqs, 32: number of interrupt sources; bit 0 is reserved and is always driven 0.
- SyncStages, 2: synchroniser flops per source; 0 = no synchroniser (direct path).
- FilterCycles, 4: consecutive cycles the synchronised value must differ from the filtered value before it is accepted; 0 = filter bypass.
- EdgeMask, '0 (NumIrqs bits): bit=1 means the source is edge-triggered (rising edge after polarity correction).
- ActiveLow, '0 (NumIrqs bits): bit=1 means the raw input is inverted before synchronisation.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; synchronous, active-high.
- irq_i  in  NumIrqs  raw device interrupt lines; may be asynchronous to clk_i.
- enable_i  in  NumIrqs  per-source enable; synchronous to clk_i.
- interrupts_o  out  NumIrqs  conditioned interrupts to the PLIC.
- edge_trigger_o  out  NumIrqs  edge-type flags to the PLIC; constant, equals EdgeMask with bit 0 forced 0.

Behaviour:
Interface: one clock; reset is synchronous and active-high (`clk_i`, `rst_i`).

Per-source datapath:
- pol = irq_i[i] ^ ActiveLow[i].
- pol feeds a chain of SyncStages flops whose output is `s`; with SyncStages=0, `s` = pol.

Filter (FilterCycles > 0):
- State: register `filt`, counter `cnt` of width $clog2(FilterCycles).
- If `s` == `filt`: cnt <= 0.
- Else if cnt == FilterCycles-1: filt <= `s`, cnt <= 0.
- Else: cnt <= cnt+1.
- A differing value shorter than FilterCycles consecutive cycles is discarded; the count restarts from 0 on any return to `filt`.
- FilterCycles=0: filt <= `s` every cycle, no counter.

Edge detection and output:
- Register `filt_d` <= `filt` every cycle.
- Level source: interrupts_o[i] = filt & enable_i[i].
- Edge source: interrupts_o[i] = filt & ~filt_d & enable_i[i], i.e. exactly one cycle per accepted rising edge.
- interrupts_o is combinational from registers and enable_i, with no additional register stage.

Latency:
- Input stable from sampling edge k: `filt` changes at edge k+SyncStages+FilterCycles-1.
- interrupts_o reflects the change in the following cycle; with defaults, the output is high in the cycle after the 6th edge counting k.

Reset:
- All sync flops, `filt`, `filt_d` and `cnt` clear to 0.
- interrupts_o = 0 during and after reset until a new assertion passes the filter.
- A source held active through reset re-qualifies after the full latency.
- Edge sources held active through reset produce one pulse after release.
- Reset asserted mid-filter discards any partial count.

Enable masking:
- Filtering continues while enable_i=0; only the output is gated.
- Level source: output reappears in the same cycle enable_i rises, if `filt`=1.
- Edge source: an edge accepted while disabled is lost. Enabling while `filt` is high produces no pulse.
- Bit 0: interrupts_o[0]=0 and edge_trigger_o[0]=0 regardless of inputs.

Boundary cases:
- Falling edge: no pulse.
- Re-rise on an edge source: a new pulse only after the line has been low for ≥FilterCycles cycles.
- Counter does not wrap: maximum value is FilterCycles-1.

Test Plan:
1. Defaults, irq_i[1] 0→1 held → interrupts_o[1] rises in the cycle after the 6th edge from first sampling; stays high until irq_i[1] low for ≥4 cycles, then falls with the same 6-edge latency.
2. Glitch rejection: irq_i[2] high for 3 cycles then low → interrupts_o[2] stays 0. Then high 3, low 1, high 3 → still 0. Then high 4 → asserts.
3. EdgeMask[3]=1, irq_i[3] high 20 cycles → exactly one 1-cycle pulse on interrupts_o[3]; edge_trigger_o[3]=1. Low 10 cycles then high again → second single pulse.
4. enable_i[1]=0 while level asserted → interrupts_o[1]=0; raise enable_i → output 1 in the same cycle. For an edge source with the edge accepted while disabled, enabling afterwards → no pulse.
5. ActiveLow[4]=1, irq_i[4] driven 0 → interrupts_o[4]=1 after latency. rst_i pulsed mid-assertion → output 0 during reset, then re-asserts 6 edges after release.
6. SyncStages=0, FilterCycles=0 build: irq_i[5] rising before edge k → interrupts_o[5] high in the cycle after edge k. irq_i[0] toggled → interrupts_o[0] remains 0.
